// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register sitting directly behind the sign extender. On each
// accepted instruction it forms the ALU operands, the store data, the
// write-back destination and the branch target, and presents them to EX
// one cycle later.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   in_valid/in_ready handshake with the decode stage (in_ready is combinational)
//   pc_plus4          PC+4 of the decoded instruction
//   rs_data, rt_data  register-file read ports A and B
//   imm_ext           sign-extended immediate
//   rt_addr, rd_addr  candidate destination register fields
//   alu_src, zext, reg_dst, alu_ctrl_in,
//   mem_read_in, mem_write_in, reg_write_in, branch_in   decode control
//   flush             squash the contents of this stage (taken branch / jump)
//   out_valid/out_ready handshake with the EX stage
//   alu_a, alu_b, store_data, dest_reg, branch_target, alu_ctrl,
//   mem_read, mem_write, reg_write, branch               registered EX outputs
// ----------------------------------------------------------------------------
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              alu_src,
    input  logic              zext,
    input  logic              reg_dst,
    input  logic [CTRL_W-1:0] alu_ctrl_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    input  logic              branch_in,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] dest_reg,
    output logic [DATA_W-1:0] branch_target,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              branch
);

    // Pipeline registers
    logic              out_valid_r;
    logic [DATA_W-1:0] alu_a_r;
    logic [DATA_W-1:0] alu_b_r;
    logic [DATA_W-1:0] store_data_r;
    logic [REG_AW-1:0] dest_reg_r;
    logic [DATA_W-1:0] branch_target_r;
    logic [CTRL_W-1:0] alu_ctrl_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              reg_write_r;
    logic              branch_r;

    // Combinational operand formation
    logic              accept_s;
    logic [DATA_W-1:0] imm_op_s;
    logic [DATA_W-1:0] alu_b_s;
    logic [REG_AW-1:0] dest_reg_s;
    logic [DATA_W-1:0] branch_target_s;

    // Ready is deliberately not gated by flush so decode never sees a
    // flush-dependent combinational path back through this stage.
    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready && !flush;

    // Form operands, destination and branch target from the decode inputs.
    always_comb begin
        imm_op_s        = {DATA_W{1'b0}};
        alu_b_s         = {DATA_W{1'b0}};
        dest_reg_s      = {REG_AW{1'b0}};
        branch_target_s = {DATA_W{1'b0}};

        // Logical immediates (andi/ori/xori) take the raw low half-word.
        if (zext) begin
            imm_op_s = {{(DATA_W-16){1'b0}}, imm_ext[15:0]};
        end else begin
            imm_op_s = imm_ext;
        end

        if (alu_src) begin
            alu_b_s = imm_op_s;
        end else begin
            alu_b_s = rt_data;
        end

        if (reg_dst) begin
            dest_reg_s = rd_addr;
        end else begin
            dest_reg_s = rt_addr;
        end

        // Branch offsets are always signed word offsets; wrap is silent.
        branch_target_s = pc_plus4 + {imm_ext[DATA_W-3:0], 2'b00};
    end

    // Stage register: reset, then flush, then capture, then drain, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r     <= 1'b0;
            alu_a_r         <= {DATA_W{1'b0}};
            alu_b_r         <= {DATA_W{1'b0}};
            store_data_r    <= {DATA_W{1'b0}};
            dest_reg_r      <= {REG_AW{1'b0}};
            branch_target_r <= {DATA_W{1'b0}};
            alu_ctrl_r      <= {CTRL_W{1'b0}};
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            reg_write_r     <= 1'b0;
            branch_r        <= 1'b0;
        end else if (flush) begin
            // Kill the instruction and its architectural side effects; the
            // remaining data fields are harmless while out_valid is low.
            out_valid_r <= 1'b0;
            mem_write_r <= 1'b0;
            reg_write_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r     <= 1'b1;
            alu_a_r         <= rs_data;
            alu_b_r         <= alu_b_s;
            store_data_r    <= rt_data;
            dest_reg_r      <= dest_reg_s;
            branch_target_r <= branch_target_s;
            alu_ctrl_r      <= alu_ctrl_in;
            mem_read_r      <= mem_read_in;
            mem_write_r     <= mem_write_in;
            reg_write_r     <= reg_write_in;
            branch_r        <= branch_in;
        end else if (out_ready) begin
            // Drain: EX took the instruction and nothing new arrived.
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid     = out_valid_r;
    assign alu_a         = alu_a_r;
    assign alu_b         = alu_b_r;
    assign store_data    = store_data_r;
    assign dest_reg      = dest_reg_r;
    assign branch_target = branch_target_r;
    assign alu_ctrl      = alu_ctrl_r;
    assign mem_read      = mem_read_r;
    assign mem_write     = mem_write_r;
    assign reg_write     = reg_write_r;
    assign branch        = branch_r;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Directed-vector bench for id_ex_operand_stage. A behavioural model of the
// stage tracks the expected outputs; a compare process checks every output
// on each falling edge, and the stimulus sequence pins the model with
// hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_plus4, rs_data, rt_data, imm_ext;
    logic [4:0]  rt_addr, rd_addr;
    logic        alu_src, zext, reg_dst;
    logic [3:0]  alu_ctrl_in;
    logic        mem_read_in, mem_write_in, reg_write_in, branch_in;
    logic        flush, out_ready, out_valid;
    logic [31:0] alu_a, alu_b, store_data, branch_target;
    logic [4:0]  dest_reg;
    logic [3:0]  alu_ctrl;
    logic        mem_read, mem_write, reg_write, branch;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc_plus4(pc_plus4), .rs_data(rs_data), .rt_data(rt_data),
        .imm_ext(imm_ext), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alu_src(alu_src), .zext(zext), .reg_dst(reg_dst),
        .alu_ctrl_in(alu_ctrl_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .branch_in(branch_in), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b),
        .store_data(store_data), .dest_reg(dest_reg),
        .branch_target(branch_target), .alu_ctrl(alu_ctrl),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .branch(branch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid;
    logic [31:0] m_a, m_b, m_sd, m_bt;
    logic [4:0]  m_dst;
    logic [3:0]  m_ctrl;
    logic        m_mr, m_mw, m_rw, m_br;

    // Model: an occupied slot either leaves (consumed/flushed) or stays; a
    // new instruction enters only when the slot is free or being consumed.
    always @(posedge clk) begin
        bit take;
        if (!rst_n) begin
            m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_sd = 32'd0; m_bt = 32'd0;
            m_dst = 5'd0; m_ctrl = 4'd0; m_mr = 1'b0; m_mw = 1'b0; m_rw = 1'b0; m_br = 1'b0;
        end else begin
            take = in_valid && (!m_valid || out_ready) && !flush;
            if (take) begin
                m_a   = rs_data;
                m_b   = alu_src ? (zext ? (imm_ext & 32'h0000_FFFF) : imm_ext) : rt_data;
                m_sd  = rt_data;
                m_dst = reg_dst ? rd_addr : rt_addr;
                m_bt  = 32'(pc_plus4 + imm_ext * 32'd4);
                m_ctrl = alu_ctrl_in;
                m_mr = mem_read_in; m_mw = mem_write_in; m_rw = reg_write_in; m_br = branch_in;
            end
            if (flush) begin
                m_mw = 1'b0;
                m_rw = 1'b0;
            end
            m_valid = !flush && (take || (m_valid && !out_ready));
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("store_data", store_data, m_sd);
            chk("dest_reg", {27'd0, dest_reg}, {27'd0, m_dst});
            chk("branch_target", branch_target, m_bt);
            chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_ctrl});
            chk("ctrl_bits", {28'd0, mem_read, mem_write, reg_write, branch},
                {28'd0, m_mr, m_mw, m_rw, m_br});
        end
    end

    // Apply the current inputs at the next rising edge; return just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        pc_plus4 = 32'h0000_0040; rs_data = 32'h1111_1111; rt_data = 32'h2222_2222;
        imm_ext = 32'h0000_0005; rt_addr = 5'd1; rd_addr = 5'd2;
        alu_src = 1'b0; zext = 1'b0; reg_dst = 1'b0; alu_ctrl_in = 4'h3;
        mem_read_in = 1'b1; mem_write_in = 1'b1; reg_write_in = 1'b1; branch_in = 1'b1;

        // Reset for two cycles with a valid instruction presented.
        step(); step();
        cmp_en = 1'b1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset alu_a", alu_a, 32'd0);
        chk("reset branch_target", branch_target, 32'd0);
        chk("reset ctrl", {28'd0, mem_read, mem_write, reg_write, branch}, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mem_read_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; branch_in = 1'b0;
        step();
        chk("ready after reset", {31'd0, in_ready}, 32'd1);

        // Positive immediate.
        in_valid = 1'b1; rs_data = 32'h0000_0010; imm_ext = 32'h0000_7FFF;
        alu_src = 1'b1; zext = 1'b0; pc_plus4 = 32'h0000_0100;
        step();
        chk("pos alu_b", alu_b, 32'h0000_7FFF);
        chk("pos alu_a", alu_a, 32'h0000_0010);
        chk("pos branch_target", branch_target, 32'h0002_00FC);
        chk("pos out_valid", {31'd0, out_valid}, 32'd1);

        // Negative immediate, then the same with zero-extension.
        imm_ext = 32'hFFFF_FDFF; branch_in = 1'b1;
        step();
        chk("neg branch_target", branch_target, 32'hFFFF_F8FC);
        chk("neg alu_b", alu_b, 32'hFFFF_FDFF);
        zext = 1'b1; reg_write_in = 1'b1; mem_write_in = 1'b1;
        step();
        chk("zext alu_b", alu_b, 32'h0000_FDFF);
        chk("zext branch_target", branch_target, 32'hFFFF_F8FC);
        chk("zext reg_write", {31'd0, reg_write}, 32'd1);

        // Stall three cycles with a different instruction waiting.
        out_ready = 1'b0; rs_data = 32'h0000_DEAD; imm_ext = 32'h0000_0001;
        zext = 1'b0; reg_write_in = 1'b0; mem_write_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall alu_a", alu_a, 32'h0000_0010);
            chk("stall alu_b", alu_b, 32'h0000_FDFF);
        end

        // Flush wins over the simultaneous accept.
        flush = 1'b1; out_ready = 1'b1;
        step();
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush wr bits", {30'd0, reg_write, mem_write}, 32'd0);
        chk("flush no capture", alu_a, 32'h0000_0010);
        flush = 1'b0; in_valid = 1'b0;
        step();

        // Four back-to-back instructions, destination alternating rd/rt.
        rd_addr = 5'd3; rt_addr = 5'd7; alu_src = 1'b0; branch_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; reg_dst = (i % 2 == 0); rs_data = 32'(i);
            step();
            chk("tput out_valid", {31'd0, out_valid}, 32'd1);
            chk("tput dest_reg", {27'd0, dest_reg}, (i % 2 == 0) ? 32'd3 : 32'd7);
        end
        in_valid = 1'b0;
        step();
        chk("drain out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain holds data", alu_a, 32'd3);

        // Branch target wrap-around.
        in_valid = 1'b1; pc_plus4 = 32'hFFFF_FFFC; imm_ext = 32'h0000_0001;
        step();
        chk("wrap branch_target", branch_target, 32'h0000_0000);

        // Reset while holding an instruction under stall.
        out_ready = 1'b0; rst_n = 1'b0;
        step();
        chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1; in_valid = 1'b0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage directly downstream of the sign extender.
- Captures the 32-bit sign-extended immediate together with the register-file operands and decode control bits.
- Produces registered ALU operands, the store data, the destination register and the branch target for the EX stage.
- Has a valid/ready handshake with stall back-pressure and a flush for taken branches and jumps.

Parameters:
- DATA_W, 32, datapath width; the immediate input is always DATA_W bits.
- REG_AW, 5, register address width.
- CTRL_W, 4, ALU control code width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  decode stage presents a valid instruction
- in_ready  output  1  stage can accept this cycle
- pc_plus4  input  DATA_W  PC+4 of the decoded instruction
- rs_data  input  DATA_W  register-file read port A
- rt_data  input  DATA_W  register-file read port B
- imm_ext  input  DATA_W  sign-extended immediate from the sign extender
- rt_addr  input  REG_AW  rt field
- rd_addr  input  REG_AW  rd field
- alu_src  input  1  1 = operand B is the immediate, 0 = rt_data
- zext  input  1  1 = zero-extend the immediate (andi/ori/xori)
- reg_dst  input  1  1 = destination is rd, 0 = rt
- alu_ctrl_in  input  CTRL_W  ALU operation code
- mem_read_in, mem_write_in, reg_write_in, branch_in  input  1 each  control bits
- flush  input  1  kill the contents of this stage
- out_ready  input  1  EX stage accepts this cycle
- out_valid  output  1  registered outputs hold a valid instruction
- alu_a, alu_b  output  DATA_W  ALU operands
- store_data  output  DATA_W  rt_data for sw
- dest_reg  output  REG_AW  selected write-back register
- branch_target  output  DATA_W  pc_plus4 + (immediate << 2)
- alu_ctrl  output  CTRL_W  registered alu_ctrl_in
- mem_read, mem_write, reg_write, branch  output  1 each  registered control bits

Behaviour:
- Clock: single clock; all state updates on the rising edge of clk.
- Reset: synchronous and active-low; when rst_n=0 at an edge, every registered output clears to 0, including out_valid.
- Reset mid-transfer: the held instruction is discarded and in_ready is 1 on the following cycle.
- in_ready is combinational: in_ready = !out_valid || out_ready.
- Accept condition: in_valid && in_ready, with no flush and rst_n=1. Latency is 1 cycle: the result is visible the cycle after accept.
- Stall: out_valid=1 and out_ready=0. All outputs hold their values and in_ready=0.
- Drain: out_valid=1, out_ready=1 and in_valid=0 gives out_valid=0 next cycle. Data registers may hold stale values but must not change when no capture occurs.
- Flush: flush=1 at an edge forces out_valid=0, mem_write=0 and reg_write=0 next cycle.
  - Flush takes priority over a simultaneous accept and over a stall.
  - in_ready is not gated by flush.
- Reset has priority over flush.
- Operand formation on capture:
  - alu_a = rs_data.
  - imm_op = zext ? {16'b0, imm_ext[15:0]} : imm_ext.
  - alu_b = alu_src ? imm_op : rt_data.
  - store_data = rt_data.
  - dest_reg = reg_dst ? rd_addr : rt_addr.
- Branch target:
  - branch_target = pc_plus4 + {imm_ext[DATA_W-3:0], 2'b00}, computed modulo 2^DATA_W.
  - Wrap-around is silent, no overflow flag.
  - Always uses the sign-extended form, regardless of zext.
- No state machine beyond the out_valid occupancy bit.
- Back-to-back accepts give full throughput: one instruction per cycle when out_ready=1.

Test Plan:
- Reset with rst_n=0 for 2 cycles while in_valid=1 -> all outputs 0, out_valid=0. After release, in_ready=1.
- imm_ext=0x00007FFF, alu_src=1, zext=0, rs_data=0x10, pc_plus4=0x100, accept -> next cycle alu_b=0x00007FFF, alu_a=0x10, branch_target=0x0002_00FC, out_valid=1.
- Negative immediate: imm_ext=0xFFFFFDFF, pc_plus4=0x100, branch_in=1 -> branch_target=0xFFFFF8FC, alu_b=0xFFFFFDFF.
- Same input with zext=1 -> alu_b=0x0000FDFF and branch_target still 0xFFFFF8FC.
- Stall and flush:
  - Hold out_ready=0 for 3 cycles with a new in_valid present -> outputs unchanged and in_ready=0 throughout.
  - Then assert flush together with out_ready=1 -> out_valid=0, reg_write=0 and mem_write=0 next cycle, and the pending input is not captured.
- Throughput: 4 back-to-back instructions with out_ready=1 and reg_dst alternating 1/0 (rd=3, rt=7) -> out_valid continuously 1 for 4 cycles, dest_reg sequence 3, 7, 3, 7.
